// File: rtl/guess_game_pkg.sv
// Shared types and helpers for the number-guessing game controller.
//   state_e      : sequencer states
//   WL_*         : WINorLOSE display codes
//   HINT_*       : higher/lower hint display codes
//   time_for     : seconds per round for a difficulty (1..3, anything else -> 1)
//   guesses_for  : guess budget per round for a difficulty
//   bcd_to_bin   : three BCD digits -> 10-bit unsigned value
package guess_game_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_WIN,
      S_LOSE
   } state_e;

   localparam logic [1:0] WL_LOSE     = 2'd0;
   localparam logic [1:0] WL_WIN      = 2'd1;
   localparam logic [1:0] WL_PLAY     = 2'd3;

   localparam logic [1:0] HINT_LOWER  = 2'd0;
   localparam logic [1:0] HINT_HIGHER = 2'd1;
   localparam logic [1:0] HINT_NONE   = 2'd2;

   function automatic logic [7:0] time_for(input logic [1:0] diff);
      case (diff)
         2'd2:    return 8'd60;
         2'd3:    return 8'd30;
         default: return 8'd90;
      endcase
   endfunction

   function automatic logic [2:0] guesses_for(input logic [1:0] diff);
      case (diff)
         2'd2:    return 3'd4;
         2'd3:    return 3'd3;
         default: return 3'd5;
      endcase
   endfunction

   // Only meaningful for digits 0..9; callers qualify the result.
   function automatic logic [9:0] bcd_to_bin(input logic [3:0] hund,
                                             input logic [3:0] tens,
                                             input logic [3:0] units);
      return 10'(hund) * 10'd100 + 10'(tens) * 10'd10 + 10'(units);
   endfunction

endpackage

// File: rtl/guess_game_if.sv
// Player-side and display-side signals of the game controller.
//   master : drives start, diff_sel, submit and the guess digits; observes the display outputs
//   slave  : the controller; drives the display outputs (timer, budget, hint, round, difficulty, result)
interface guess_game_if;
   logic       start;
   logic [1:0] diff_sel;
   logic       submit;
   logic [3:0] guess1;
   logic [3:0] guess2;
   logic [3:0] guess3;
   logic [7:0] timer;
   logic [2:0] guesses;
   logic [1:0] hint;
   logic [1:0] round;
   logic [1:0] difficulty;
   logic [1:0] WINorLOSE;

   modport master (
      output start, diff_sel, submit, guess1, guess2, guess3,
      input  timer, guesses, hint, round, difficulty, WINorLOSE
   );

   modport slave (
      input  start, diff_sel, submit, guess1, guess2, guess3,
      output timer, guesses, hint, round, difficulty, WINorLOSE
   );
endinterface

// File: rtl/guess_game_ctrl_bcd_secret_gen.sv
// Free-running 3-digit BCD counter, 000..999, +1 per clock, wraps to 000.
// The controller samples it when a round loads, so the secret depends on
// when the player pressed start / guessed.
//   clk    : system clock
//   rst    : asynchronous active-high reset to 000
//   secret : {hundreds, tens, units} BCD digits
module bcd_secret_gen (
   input  logic        clk,
   input  logic        rst,
   output logic [11:0] secret
);

   logic [3:0] hund, tens, units;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hund  <= '0;
         tens  <= '0;
         units <= '0;
      end else if (units == 4'd9) begin
         units <= '0;
         if (tens == 4'd9) begin
            tens <= '0;
            hund <= (hund == 4'd9) ? 4'd0 : hund + 4'd1;
         end else begin
            tens <= tens + 4'd1;
         end
      end else begin
         units <= units + 4'd1;
      end
   end

   assign secret = {hund, tens, units};

endmodule

// File: rtl/guess_game_ctrl.sv
// Number-guessing game sequencer.
// Latches difficulty on start, loads a BCD secret per round, runs a
// 1 s countdown and a guess budget, and produces higher/lower hints.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : slave side of guess_game_if
//                in : start, diff_sel, submit, guess digits
//                out: timer (8'hFF blank), remaining guesses, hint,
//                     round, difficulty, WINorLOSE
module guess_game_ctrl
   import guess_game_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 50_000_000,
   parameter int unsigned NUM_ROUNDS    = 3
) (
   input  logic        clk,
   input  logic        reset,
   guess_game_if.slave bus
);

   localparam logic [31:0] TICK_LAST  = 32'(TICKS_PER_SEC - 1);
   localparam logic [1:0]  LAST_ROUND = 2'(NUM_ROUNDS);

   state_e      state, state_n;
   logic [31:0] presc, presc_n;
   logic [7:0]  timer_q, timer_n;
   logic [2:0]  guesses_q, guesses_n;
   logic [1:0]  hint_q, hint_n;
   logic [1:0]  round_q, round_n;
   logic [1:0]  diff_q, diff_n;
   logic [1:0]  wl_q, wl_n;
   logic [9:0]  secret_q, secret_n;

   logic [11:0] secret_bcd;
   logic [9:0]  guess_val;
   logic        digits_ok;
   logic        tick;
   logic        hit;

   bcd_secret_gen u_secret (
      .clk    (clk),
      .rst    (reset),
      .secret (secret_bcd)
   );

   assign digits_ok = (bus.guess1 <= 4'd9) && (bus.guess2 <= 4'd9) && (bus.guess3 <= 4'd9);
   assign guess_val = bcd_to_bin(bus.guess1, bus.guess2, bus.guess3);
   assign tick      = (presc == TICK_LAST);
   assign hit       = bus.submit && digits_ok && (guess_val == secret_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         presc     <= '0;
         timer_q   <= 8'hFF;
         guesses_q <= '0;
         hint_q    <= HINT_NONE;
         round_q   <= '0;
         diff_q    <= '0;
         wl_q      <= WL_PLAY;
         secret_q  <= '0;
      end else begin
         state     <= state_n;
         presc     <= presc_n;
         timer_q   <= timer_n;
         guesses_q <= guesses_n;
         hint_q    <= hint_n;
         round_q   <= round_n;
         diff_q    <= diff_n;
         wl_q      <= wl_n;
         secret_q  <= secret_n;
      end
   end

   always_comb begin
      state_n   = state;
      presc_n   = presc;
      timer_n   = timer_q;
      guesses_n = guesses_q;
      hint_n    = hint_q;
      round_n   = round_q;
      diff_n    = diff_q;
      wl_n      = wl_q;
      secret_n  = secret_q;

      case (state)
         S_IDLE, S_WIN, S_LOSE: begin
            if (bus.start) begin
               diff_n  = (bus.diff_sel == 2'd0) ? 2'd1 : bus.diff_sel;
               round_n = 2'd1;
               wl_n    = WL_PLAY;
               state_n = S_LOAD;
            end
         end

         S_LOAD: begin
            secret_n  = bcd_to_bin(secret_bcd[11:8], secret_bcd[7:4], secret_bcd[3:0]);
            timer_n   = time_for(diff_q);
            guesses_n = guesses_for(diff_q);
            hint_n    = HINT_NONE;
            presc_n   = '0;
            state_n   = S_PLAY;
         end

         S_PLAY: begin
            presc_n = tick ? 32'd0 : presc + 32'd1;

            // The guess is resolved before the expiry tick, so a correct
            // guess on the expiry edge still wins the round.
            if (hit) begin
               if (round_q < LAST_ROUND) begin
                  round_n = round_q + 2'd1;
                  state_n = S_LOAD;
               end else begin
                  wl_n    = WL_WIN;
                  state_n = S_WIN;
               end
            end else begin
               if (bus.submit && digits_ok) begin
                  hint_n    = (secret_q > guess_val) ? HINT_HIGHER : HINT_LOWER;
                  guesses_n = guesses_q - 3'd1;
                  if (guesses_q == 3'd1) begin
                     wl_n    = WL_LOSE;
                     state_n = S_LOSE;
                  end
               end
               if (tick) begin
                  if (timer_q == 8'd0) begin
                     wl_n    = WL_LOSE;
                     state_n = S_LOSE;
                  end else begin
                     timer_n = timer_q - 8'd1;
                  end
               end
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   assign bus.timer      = timer_q;
   assign bus.guesses    = guesses_q;
   assign bus.hint       = hint_q;
   assign bus.round      = round_q;
   assign bus.difficulty = diff_q;
   assign bus.WINorLOSE  = wl_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl. Stimulus pushes the expected
// display outputs for a given cycle into a queue; a monitor compares on
// the falling edge of that cycle.
module tb_guess_game_ctrl;

   localparam int unsigned TPS = 4;

   logic clk = 1'b0;
   logic reset;

   guess_game_if bus ();

   guess_game_ctrl #(
      .TICKS_PER_SEC (TPS),
      .NUM_ROUNDS    (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      string       name;
      bit          bad;
      logic [7:0]  t;
      logic [2:0]  g;
      logic [1:0]  h;
      logic [1:0]  r;
      logic [1:0]  d;
      logic [1:0]  w;
   } exp_t;

   exp_t q[$];

   int unsigned cyc = 0;
   int unsigned sc  = 0;
   int unsigned compared   = 0;
   int unsigned mismatched = 0;

   // Posedge counter and the secret counter's known free-running sequence.
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk or posedge reset) begin
      if (reset) sc <= 0;
      else       sc <= (sc == 999) ? 0 : sc + 1;
   end

   logic [7:0] e_timer;
   logic [2:0] e_guesses;
   logic [1:0] e_hint, e_round, e_diff, e_wl;
   int unsigned load_cyc = 0;
   int unsigned secret   = 0;
   int unsigned t0       = 0;

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         compared++;
         if (e.bad) begin
            mismatched++;
            $display("FAIL %s: wait bound expired at cycle %0d, required the awaited condition", e.name, cyc);
         end else if (e.cyc != cyc) begin
            mismatched++;
            $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
         end else if (bus.timer !== e.t || bus.guesses !== e.g || bus.hint !== e.h ||
                      bus.round !== e.r || bus.difficulty !== e.d || bus.WINorLOSE !== e.w) begin
            mismatched++;
            $display("FAIL %s: got t=%h g=%0d h=%0d r=%0d d=%0d wl=%0d, required t=%h g=%0d h=%0d r=%0d d=%0d wl=%0d",
                     e.name, bus.timer, bus.guesses, bus.hint, bus.round, bus.difficulty, bus.WINorLOSE,
                     e.t, e.g, e.h, e.r, e.d, e.w);
         end
      end
   end

   function automatic int tt(input logic [1:0] d);
      return (d == 2'd3) ? 30 : (d == 2'd2) ? 60 : 90;
   endfunction

   function automatic logic [2:0] gg(input logic [1:0] d);
      return (d == 2'd3) ? 3'd3 : (d == 2'd2) ? 3'd4 : 3'd5;
   endfunction

   // Timer value after the next edge: one decrement every TPS PLAY cycles.
   function automatic logic [7:0] pt();
      return 8'(int'(t0) - int'((cyc + 1 - load_cyc) / TPS));
   endfunction

   task automatic push(input string name, input bit bad);
      exp_t e;
      e.cyc  = cyc + 1;
      e.name = name;
      e.bad  = bad;
      e.t    = e_timer;
      e.g    = e_guesses;
      e.h    = e_hint;
      e.r    = e_round;
      e.d    = e_diff;
      e.w    = e_wl;
      q.push_back(e);
   endtask

   task automatic step(input string name);
      push(name, 1'b0);
      @(negedge clk);
      #1;
      bus.start  = 1'b0;
      bus.submit = 1'b0;
   endtask

   task automatic wait_to(input int unsigned c);
      while (cyc + 1 < c) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic load_step(input string name);
      load_cyc  = cyc + 1;
      t0        = tt(e_diff);
      e_timer   = 8'(t0);
      e_guesses = gg(e_diff);
      e_hint    = 2'd2;
      step(name);
   endtask

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      bus.guess1 = a;
      bus.guess2 = b;
      bus.guess3 = c;
      bus.submit = 1'b1;
   endtask

   // Submits the current secret; the next LOAD captures the counter value
   // one cycle after this submit edge.
   task automatic drive_hit();
      drive(4'(secret / 100), 4'((secret / 10) % 10), 4'(secret % 10));
      secret = (sc + 1) % 1000;
   endtask

   task automatic start_game(input logic [1:0] ds, input int unsigned target,
                             input logic [1:0] d_exp, input string name);
      int unsigned n = 0;
      while (sc != (target + 999) % 1000 && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 2000) begin
         push({name, "_wait"}, 1'b1);
         @(negedge clk);
         #1;
      end
      secret       = (sc + 1) % 1000;
      bus.start    = 1'b1;
      bus.diff_sel = ds;
      e_round      = 2'd1;
      e_diff       = d_exp;
      e_wl         = 2'd3;
      step({name, "_start"});
      load_step({name, "_load"});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got cycle %0d without finishing, required finish", cyc);
      $fatal(1);
   end

   initial begin
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.diff_sel = 2'd0;
      bus.submit   = 1'b0;
      bus.guess1   = 4'd0;
      bus.guess2   = 4'd0;
      bus.guess3   = 4'd0;
      repeat (2) @(negedge clk);
      #1;
      e_timer = 8'hFF; e_guesses = 3'd0; e_hint = 2'd2;
      e_round = 2'd0;  e_diff = 2'd0;    e_wl = 2'd3;
      step("reset_values");
      reset = 1'b0;
      step("idle_after_reset");

      // diff_sel 0 -> difficulty 1, secret 512, hints, non-BCD digits, 3 rounds to WIN
      start_game(2'd0, 512, 2'd1, "d0");
      drive(4'd3, 4'd0, 4'd0);  e_guesses = 3'd4; e_hint = 2'd1; e_timer = pt(); step("guess_300");
      drive(4'd7, 4'd0, 4'd0);  e_guesses = 3'd3; e_hint = 2'd0; e_timer = pt(); step("guess_700");
      drive(4'd5, 4'hA, 4'd2);  e_timer = pt(); step("tens_not_bcd");
      drive(4'hF, 4'd1, 4'd2);  e_timer = pt(); step("hund_not_bcd_on_tick");
      drive(4'd5, 4'd1, 4'd1);  e_guesses = 3'd2; e_hint = 2'd1; e_timer = pt(); step("guess_511");
      drive_hit();              e_round = 2'd2; e_timer = pt(); step("hit_r1");
      load_step("load_r2");
      drive_hit();              e_round = 2'd3; e_timer = pt(); step("hit_r2");
      load_step("load_r3");
      drive_hit();              e_wl = 2'd1; e_timer = pt(); step("win");
      drive(4'd0, 4'd0, 4'd0);  step("win_ignores_submit");

      // diff 3, wrong guesses exhaust the budget
      start_game(2'd3, 250, 2'd3, "d3");
      drive(4'd2, 4'd4, 4'd9);  e_guesses = 3'd2; e_hint = 2'd1; e_timer = pt(); step("guess_249");
      drive(4'd9, 4'd9, 4'd9);  e_guesses = 3'd1; e_hint = 2'd0; e_timer = pt(); step("guess_999");
      drive(4'd2, 4'd5, 4'd1);  e_guesses = 3'd0; e_hint = 2'd0; e_wl = 2'd0; e_timer = pt(); step("guess_251_lose");
      drive(4'd2, 4'd5, 4'd0);  step("lose_ignores_submit");

      // timer expiry
      start_game(2'd3, 777, 2'd3, "expire");
      wait_to(load_cyc + 4);   e_timer = pt(); step("first_tick");
      wait_to(load_cyc + 10);  bus.start = 1'b1; bus.diff_sel = 2'd1; e_timer = pt(); step("start_in_play");
      wait_to(load_cyc + 120); e_timer = pt(); step("timer_zero");
      wait_to(load_cyc + 123); e_timer = 8'd0; step("zero_still_playing");
      wait_to(load_cyc + 124); e_timer = 8'd0; e_wl = 2'd0; step("expiry_lose");

      // correct guess on the expiry edge beats the expiry
      start_game(2'd3, 400, 2'd3, "race");
      wait_to(load_cyc + 124);
      drive_hit(); e_round = 2'd2; e_timer = 8'd0; step("hit_on_expiry");
      load_step("race_load");

      // reset mid-play
      reset = 1'b1;
      e_timer = 8'hFF; e_guesses = 3'd0; e_hint = 2'd2;
      e_round = 2'd0;  e_diff = 2'd0;    e_wl = 2'd3;
      step("reset_in_round2");
      reset = 1'b0;
      step("idle_after_reset2");
      start_game(2'd2, 100, 2'd2, "d2");
      wait_to(load_cyc + 52); e_timer = pt(); step("timer_47");
      reset = 1'b1;
      e_timer = 8'hFF; e_guesses = 3'd0; e_hint = 2'd2;
      e_round = 2'd0;  e_diff = 2'd0;    e_wl = 2'd3;
      step("reset_mid_play");
      reset = 1'b0;
      step("idle_after_reset3");

      repeat (3) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
